// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_t   - controller states (RESET_FLUSH, RUN, MEM_WAIT)
//   latch_ctrl_t - enable/clear pair for one pipeline latch (clear wins)
package core_pkg;
  localparam int REG_ADDR_BITS = 5;
  localparam int DWORD_BITS = 32;
  typedef enum logic [1:0] {RESET_FLUSH, RUN, MEM_WAIT} hz_state_t;
  typedef struct packed {
    logic en;
    logic clr;
  } latch_ctrl_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the 5-stage datapath and the hazard controller.
//   master (datapath): drives ID/EX/MEM stage info, receives latch controls and counters
//   slave (controller): receives stage info, drives pc_en, latch en/clr pairs, mem_fault, counters
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_BITS = core_pkg::REG_ADDR_BITS
);
  logic [REG_ADDR_BITS-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, dmem_req, dmem_ack;
  logic pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr, mem_fault;
  logic [core_pkg::DWORD_BITS-1:0] stall_cycles, flush_count;
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_redirect, dmem_req, dmem_ack,
    input  pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr, mem_fault,
           stall_cycles, flush_count
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_redirect, dmem_req, dmem_ack,
    output pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr, mem_fault,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator.
//   rs1_i/rs2_i, use_rs1_i/use_rs2_i - sources read by the ID instruction
//   rd_i, is_load_i                  - destination and load flag of the EX instruction
//   hazard_o                         - ID needs a value the EX load has not produced yet
module hazard_detect #(
  parameter int W = 5
) (
  input  logic [W-1:0] rs1_i,
  input  logic [W-1:0] rs2_i,
  input  logic [W-1:0] rd_i,
  input  logic         use_rs1_i,
  input  logic         use_rs2_i,
  input  logic         is_load_i,
  output logic         hazard_o
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard_o = is_load_i && rd_i != '0 &&
                    ((use_rs1_i && rs1_i == rd_i) || (use_rs2_i && rs2_i == rd_i));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline latch control for load-use stalls, EX redirects and data-memory waits.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - slave side of pipe_hazard_ctrl_if: stage info in; pc_en, fd/de/em/mw en+clr,
//                mem_fault pulse, stall_cycles/flush_count out
//   Macro PIPE_PERF_CNT_EN enables the two performance counters; otherwise they read 0.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_hazard_ctrl_if.slave      bus
);
  localparam int TO_BITS = $clog2(MEM_TIMEOUT + 1);
  hz_state_t state_q, state_d;
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic ld_use, rst_st, timeout, rel, freeze, redir, luse;
  latch_ctrl_t fd, de, em, mw;
  hazard_detect #(.W(REG_ADDR_BITS)) u_hd (
    .rs1_i(bus.id_rs1),
    .rs2_i(bus.id_rs2),
    .rd_i(bus.ex_rd),
    .use_rs1_i(bus.id_use_rs1),
    .use_rs2_i(bus.id_use_rs2),
    .is_load_i(bus.ex_is_load),
    .hazard_o(ld_use)
  );
  always_comb begin
    rst_st = state_q == RESET_FLUSH;
    timeout = state_q == MEM_WAIT && !bus.dmem_ack && cnt_q == TO_BITS'(MEM_TIMEOUT);
    rel = state_q == MEM_WAIT && (bus.dmem_ack || timeout);
    // the wait is entered from RUN on an unacked request and held until ack or timeout
    freeze = state_q == MEM_WAIT ? !rel : state_q == RUN && bus.dmem_req && !bus.dmem_ack;
    // redirect beats load-use: the stalled ID instruction is on the wrong path anyway
    redir = !rst_st && !freeze && bus.ex_redirect;
    luse = !rst_st && !freeze && !bus.ex_redirect && ld_use;
    fd = '{en: !(rst_st || freeze || luse), clr: rst_st || redir};
    de = '{en: !(rst_st || freeze), clr: rst_st || redir || luse};
    em = '{en: !(rst_st || freeze), clr: rst_st};
    mw = '{en: !rst_st, clr: rst_st || freeze};
    state_d = rst_st ? RUN : freeze ? MEM_WAIT : RUN;
    cnt_d = state_d == MEM_WAIT ? cnt_q + TO_BITS'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RESET_FLUSH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  assign bus.pc_en = !(rst_st || freeze || luse);
  assign bus.fd_en = fd.en;
  assign bus.fd_clr = fd.clr;
  assign bus.de_en = de.en;
  assign bus.de_clr = de.clr;
  assign bus.em_en = em.en;
  assign bus.em_clr = em.clr;
  assign bus.mw_en = mw.en;
  assign bus.mw_clr = mw.clr;
  assign bus.mem_fault = timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [DWORD_BITS-1:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!rst_st && !bus.pc_en) stall_q <= stall_q + 1'b1;
      if (redir) flush_q <= flush_q + 1'b1;
    end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 16;
  localparam int HOLD = 0, LOAD = 1, CLEAR = 2;
  logic clk = 0;
  logic rst_n;
  int n_tests = 0, n_fail = 0;
  bit m_flush = 1, m_wait = 0;
  int m_n = 0;
  int unsigned m_stall = 0, m_flushcnt = 0;
  pipe_hazard_ctrl_if #(.REG_ADDR_BITS(5)) bus ();
  pipe_hazard_ctrl #(.REG_ADDR_BITS(5), .MEM_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int act(input logic en, input logic clr);
    return clr ? CLEAR : en ? LOAD : HOLD;
  endfunction
  task automatic step(input bit r, input bit req, input bit ack, input bit redir, input bit ld,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2);
    bit haz, frozen, rel, fault, pc;
    int fd, de, em, mw;
    @(negedge clk);
    rst_n = r;
    bus.dmem_req = req;
    bus.dmem_ack = ack;
    bus.ex_redirect = redir;
    bus.ex_is_load = ld;
    bus.ex_rd = rd;
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    if (!r) begin
      m_flush = 1;
      m_wait = 0;
      m_n = 0;
      m_stall = 0;
      m_flushcnt = 0;
    end
    #2;
    haz = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    rel = 0;
    fault = 0;
    if (m_wait) begin
      rel = ack || m_n == TO;
      fault = !ack && m_n == TO;
      frozen = !rel;
    end else frozen = req && !ack;
    if (m_flush) begin
      pc = 0; fd = CLEAR; de = CLEAR; em = CLEAR; mw = CLEAR;
      fault = 0; frozen = 0;
    end else if (frozen) begin
      pc = 0; fd = HOLD; de = HOLD; em = HOLD; mw = CLEAR;
    end else if (redir) begin
      pc = 1; fd = CLEAR; de = CLEAR; em = LOAD; mw = LOAD;
    end else if (haz) begin
      pc = 0; fd = HOLD; de = CLEAR; em = LOAD; mw = LOAD;
    end else begin
      pc = 1; fd = LOAD; de = LOAD; em = LOAD; mw = LOAD;
    end
    check("pc_en", bus.pc_en, pc);
    check("fd", act(bus.fd_en, bus.fd_clr), fd);
    check("de", act(bus.de_en, bus.de_clr), de);
    check("em", act(bus.em_en, bus.em_clr), em);
    check("mw", act(bus.mw_en, bus.mw_clr), mw);
    check("mem_fault", bus.mem_fault, fault);
`ifdef PIPE_PERF_CNT_EN
    check("stall_cycles", bus.stall_cycles, m_stall);
    check("flush_count", bus.flush_count, m_flushcnt);
`else
    check("stall_cycles", bus.stall_cycles, 0);
    check("flush_count", bus.flush_count, 0);
`endif
    if (!m_flush && !pc) m_stall++;
    if (!m_flush && fd == CLEAR) m_flushcnt++;
    if (m_flush) m_flush = !r;
    else if (m_wait) begin
      if (rel) m_wait = 0;
      else m_n++;
    end else if (frozen) begin
      m_wait = 1;
      m_n = 1;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst_n = 0;
    bus.dmem_req = 0; bus.dmem_ack = 0; bus.ex_redirect = 0; bus.ex_is_load = 0;
    bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 1, 5, 0, 5, 0, 1);
    step(1, 0, 0, 0, 0, 5, 0, 5, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 7, 7, 3, 1, 0);
    step(1, 0, 0, 1, 1, 5, 5, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < TO + 1; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < TO; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      bit r, req, ack;
      r = $urandom_range(0, 399) != 0;
      req = m_wait ? 1'b1 : $urandom_range(0, 5) == 0;
      ack = m_wait ? $urandom_range(0, 11) == 0 : $urandom_range(0, 2) == 0;
      step(r, req, ack, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
